// File: rtl/seq_detector_prog.sv
// Programmable Moore sequence detector: compares the last 1..MAX_LEN valid serial
// bits against a run-time pattern and emits a registered one-cycle detect pulse.
module seq_detector_prog #(
    parameter int                 MAX_LEN       = 8,
    parameter int                 LEN_W         = $clog2(MAX_LEN) + 1,
    parameter int                 CNT_W         = 8,
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'('b1011),
    parameter int                 RESET_LEN     = 4,
    parameter bit                 RESET_OVERLAP = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clear,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l > MAX_LEN_L) begin
            return MAX_LEN_L;
        end
        return l;
    endfunction

    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < l) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    logic [MAX_LEN-1:0] history;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;

    logic [MAX_LEN-1:0] history_next;
    logic [LEN_W-1:0]   fill_next;
    logic               match;
    logic [CNT_W-1:0]   cnt_next;

    // Match is judged on the post-shift window; a config load swallows the bit.
    always_comb begin
        history_next = {history[MAX_LEN-2:0], sequence_in};
        fill_next    = (fill == MAX_LEN_L) ? fill : fill + LEN_W'(1);
        match        = in_valid && !cfg_load && (len != '0) && (fill_next >= len)
                       && (((history_next ^ pat) & len_mask(len)) == '0);
    end

    always_comb begin
        cnt_next = count_clear ? '0 : match_count;
        if (match) begin
            cnt_next = sat_inc(cnt_next);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            history      <= '0;
            fill         <= '0;
            pat          <= RESET_PATTERN;
            len          <= clamp_len(LEN_W'(RESET_LEN));
            ovl          <= RESET_OVERLAP;
            detector_out <= 1'b0;
        end else if (cfg_load) begin
            history      <= '0;
            fill         <= '0;
            pat          <= cfg_pattern;
            len          <= clamp_len(cfg_len);
            ovl          <= cfg_overlap;
            detector_out <= 1'b0;
        end else if (in_valid) begin
            history      <= history_next;
            fill         <= (match && !ovl) ? '0 : fill_next;
            detector_out <= match;
        end else begin
            detector_out <= 1'b0;
        end
    end

    // count_sat is derived from the next count so both flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            match_count <= cnt_next;
            count_sat   <= &cnt_next;
        end
    end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog (MAX_LEN=8, CNT_W=3) with immediate assertions.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int CNT_W   = 3;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               sequence_in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clear;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    int total = 0;
    int bad   = 0;

    seq_detector_prog #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sequence_in (sequence_in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clear (count_clear),
        .detector_out(detector_out),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic ld, input logic clr);
        in_valid    = v;
        sequence_in = b;
        cfg_load    = ld;
        count_clear = clr;
        @(posedge clock);
        #1;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        count_clear = 1'b0;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                        input logic o, input logic clr);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        step(1'b0, 1'b0, 1'b1, clr);
    endtask

    initial begin
        logic [7:0] bits7;
        logic [7:0] gap_pat;
        logic [11:0] long_stream;

        reset_n = 1'b0; sequence_in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clear = 1'b0;
        #12;
        check("rst_det", int'(detector_out), 0);
        check("rst_cnt", int'(match_count), 0);
        check("rst_sat", int'(count_sat), 0);
        reset_n = 1'b1;

        // Default pattern 1011, overlapping: 1,0,1,1,0,1,1
        bits7 = 8'b0101_1011;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, bits7[i], 1'b0, 1'b0);
            check($sformatf("ovl_det%0d", 7 - i), int'(detector_out), (i == 3 || i == 0) ? 1 : 0);
        end
        check("ovl_cnt", int'(match_count), 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovl_idle_det", int'(detector_out), 0);

        // Non-overlapping, count cleared on the load cycle
        load(8'b0000_1011, 4'd4, 1'b0, 1'b1);
        check("nov_load_det", int'(detector_out), 0);
        check("nov_load_cnt", int'(match_count), 0);
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, bits7[i], 1'b0, 1'b0);
            check($sformatf("nov_det%0d", 7 - i), int'(detector_out), (i == 3) ? 1 : 0);
        end
        check("nov_cnt", int'(match_count), 1);

        // Length 8 with idle gaps between every bit
        gap_pat = 8'b1110_0101;
        load(gap_pat, 4'd8, 1'b1, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, gap_pat[i], 1'b0, 1'b0);
            check($sformatf("gap_bit%0d", 8 - i), int'(detector_out), (i == 0) ? 1 : 0);
            step(1'b0, ~gap_pat[i], 1'b0, 1'b0);
            check($sformatf("gap_idle%0d", 8 - i), int'(detector_out), 0);
        end
        check("gap_cnt", int'(match_count), 1);

        // Length 0 disables detection
        load(8'b0000_0000, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("len0_det%0d", i), int'(detector_out), 0);
        end
        check("len0_cnt", int'(match_count), 0);

        // Length 12 clamps to 8: stream 0101_1110_0101 matches only at the end
        long_stream = 12'b0101_1110_0101;
        load(gap_pat, 4'd12, 1'b1, 1'b0);
        for (int i = 11; i >= 0; i--) begin
            step(1'b1, long_stream[i], 1'b0, 1'b0);
            check($sformatf("len12_det%0d", 12 - i), int'(detector_out), (i == 0) ? 1 : 0);
        end
        check("len12_cnt", int'(match_count), 1);

        // Saturating counter with len 1, pattern 1
        load(8'b0000_0001, 4'd1, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("sat_det%0d", i), int'(detector_out), 1);
            check($sformatf("sat_cnt%0d", i), int'(match_count), (i < 7) ? i : 7);
            check($sformatf("sat_flag%0d", i), int'(count_sat), (i >= 7) ? 1 : 0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_match_det", int'(detector_out), 1);
        check("clr_match_cnt", int'(match_count), 1);
        check("clr_match_sat", int'(count_sat), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_only_cnt", int'(match_count), 0);

        // cfg_load on the cycle carrying the completing bit discards it
        load(8'b0000_1011, 4'd4, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        cfg_pattern = 8'b0000_1011; cfg_len = 4'd4; cfg_overlap = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("mid_load_det", int'(detector_out), 0);
        check("mid_load_cnt", int'(match_count), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_b1", int'(detector_out), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_b2", int'(detector_out), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_b3", int'(detector_out), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_b4", int'(detector_out), 1);
        check("mid_cnt", int'(match_count), 1);

        // Asynchronous reset while detector_out is high
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_rst_det", int'(detector_out), 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_det", int'(detector_out), 0);
        check("async_rst_cnt", int'(match_count), 0);
        check("async_rst_sat", int'(count_sat), 0);
        #2;
        reset_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_b1", int'(detector_out), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_b2", int'(detector_out), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_b3", int'(detector_out), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_b4", int'(detector_out), 1);
        check("post_rst_cnt", int'(match_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Programmable, parametrised Moore sequence detector for the serial receive path. It compares the most recent 1..MAX_LEN valid serial bits against a run-time-loadable pattern and emits a registered one-cycle detect pulse. It supports overlapping and non-overlapping detection and keeps a saturating count of matches. It sits after the serial bit source and ahead of the framing/control logic, and replaces the fixed-pattern single-purpose detector.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- LEN_W, $clog2(MAX_LEN)+1: width of length fields.
- CNT_W, 8: match counter width.
- RESET_PATTERN, 'b1011 (zero-extended to MAX_LEN): pattern after reset.
- RESET_LEN, 4: pattern length after reset.
- RESET_OVERLAP, 1: overlap mode after reset.
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- sequence_in  in  1  serial data bit.
- in_valid  in  1  sequence_in is sampled only when high.
- cfg_load  in  1  one-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern. Bit [len-1] is the first bit received and bit [0] is the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- count_clear  in  1  synchronous clear of match_count.
- detector_out  out  1  registered detect pulse.
- match_count  out  CNT_W  saturating number of detections.
- count_sat  out  1  high while match_count is all-ones.

## Operation
- Internal state:
  - history: MAX_LEN-bit shift register. On each valid bit it shifts left and the new bit enters [0].
  - fill: number of valid bits since the last restart. It saturates at MAX_LEN.
  - Active configuration registers: pat, len, ovl.
- Reset values:
  - history = 0, fill = 0.
  - detector_out = 0, match_count = 0, count_sat = 0.
  - pat/len/ovl = RESET_* parameters.
- Length rules:
  - cfg_len = 0 is latched as 0, which disables detection; no match ever occurs.
  - cfg_len > MAX_LEN is clamped to MAX_LEN.
- Match condition, evaluated on a valid cycle using the post-shift history:
  - len ≠ 0, and
  - fill_next ≥ len, and
  - history_next[len-1:0] == pat[len-1:0].
- On a match:
  - detector_out is set to 1 at that edge.
  - Overlap mode: fill keeps incrementing/saturating.
  - Non-overlap mode: fill is set to 0, so the next match needs len fresh bits.
- On any edge without a match, detector_out is set to 0. Every detection is therefore exactly one cycle wide.
- match_count:
  - Increments on each match and saturates at 2^CNT_W-1.
  - count_sat = (match_count == all-ones), registered together with match_count.
- count_clear:
  - Sets match_count to 0.
  - If a match occurs on the same edge, the result is 1 (clear, then count).
- cfg_load has priority over data:
  - Latch the new configuration, set history = 0, fill = 0, detector_out = 0.
  - sequence_in on that cycle is discarded even if in_valid = 1.
  - match_count is not affected.
- in_valid = 0: history and fill hold, and detector_out returns to 0.

## Timing
- Latency: the bit completing the pattern is sampled at edge N. detector_out is high during cycle N→N+1 and drops at edge N+1 unless another match occurs then.
- Back-to-back matches in overlap mode can hold detector_out high for consecutive cycles, for example with len = 1, or with pattern 11 and a stream of 1s.
- match_count reflects a match at the same edge detector_out rises.
- A new configuration applies to bits sampled from edge cfg_load+1 onward.
- reset_n low forces all outputs to their reset values immediately, even mid-sequence. After release, a detection needs len fresh valid bits.
- No combinational path exists from inputs to outputs.

## Test plan
- **Default pattern, overlap.** After reset, send valid bits 1,0,1,1,0,1,1 on consecutive cycles. Expect detector_out pulses one cycle after the 4th and the 7th bits, and match_count = 2.
- **Non-overlap.** Load pattern 4'b1011, len 4, cfg_overlap 0, then send the same 7 bits. Expect a single pulse after the 4th bit and match_count = 1.
- **Gaps and length.**
  - Load 8'b11100101, len 8, and interleave in_valid = 0 cycles between bits. Expect one pulse, one cycle after the final valid bit, and history held during the gaps.
  - Load len 0. Expect no pulses for any input.
  - Load len 12 with MAX_LEN = 8. Expect it to behave as len 8.
- **Counter.**
  - With CNT_W = 3 and len 1, pattern 1, send 10 valid 1s. Expect match_count to stop at 7 with count_sat = 1.
  - Assert count_clear on the same edge as a match. Expect match_count = 1.
- **cfg_load mid-stream.** Send 1,0,1, then cfg_load on the cycle carrying the final 1. Expect no pulse, that bit discarded, and a match only after 4 new bits 1,0,1,1.
- **Reset mid-operation.** Assert reset_n low asynchronously between edges while detector_out = 1. Expect detector_out and match_count to go to 0 immediately, and 1,0,1 followed by 1 after release to be required for the next detection.
